slc3_mem_ctrl: RTL and testbench
================================

# slc3_mem_ctrl

SRAM access sequencer for the SLC-3 memory path. It sits between the CPU datapath (MAR/MDR and control unit) and the Mem2IO/SRAM interface. It turns a single-cycle CPU request into a correctly timed active-low CE/OE/WE/UB/LB sequence, drives write data on the shared data bus, and captures read data after a fixed number of wait states. It is address-agnostic: memory-mapped I/O (e.g. 0xFFFF) is handled downstream.

## Interface

**Parameters**
- `WAIT_STATES`, default 2: number of ACCESS cycles, legal range 1..15. Any other value must fail elaboration.
- `ADDR_W`, default 20: address width.
- `DATA_W`, default 16: data width.

**Ports**
- `Clk`  in  1  clock.
- `Reset`  in  1  asynchronous, active-high.
- `req`  in  1  start access; sampled only in IDLE.
- `we_req`  in  1  1 = write, 0 = read; sampled with `req`.
- `be`  in  2  byte enables; bit1 = upper byte, bit0 = lower byte.
- `addr`  in  ADDR_W  access address.
- `wdata`  in  DATA_W  write data.
- `busy`  out  1  high in SETUP, ACCESS and RECOVER.
- `done`  out  1  high for exactly the RECOVER cycle.
- `rdata`  out  DATA_W  last captured read data; held until the next read capture.
- `A`  out  ADDR_W  memory address.
- `CE`, `OE`, `WE`, `UB`, `LB`  out  1 each  active-low memory controls.
- `Data_CPU`  inout  DATA_W  shared data bus; driven only during writes, otherwise high-Z.

## Operation

**States:** IDLE, SETUP, ACCESS, RECOVER.

**IDLE**
- Controls: CE = OE = WE = UB = LB = 1; `Data_CPU` is Z.
- If `req` = 1 at the clock edge, latch `addr`, `we_req`, `be` and `wdata`, then go to SETUP.

**SETUP** (1 cycle)
- `A` = latched address; CE = 0; UB = ~be[1]; LB = ~be[0].
- Read: OE = 0, WE = 1.
- Write: OE = 1, WE = 1, `Data_CPU` = latched `wdata`.

**ACCESS** (`WAIT_STATES` cycles)
- Same as SETUP, except writes drive WE = 0.
- A 4-bit counter tracks the ACCESS cycles.
- Read: `rdata` <= `Data_CPU` on the edge that leaves the final ACCESS cycle.

**RECOVER** (1 cycle)
- CE = 0; OE = 1; WE = 1.
- `A`, UB/LB, and `Data_CPU` (for writes) are held, giving address/data hold after WE rises.
- `done` = 1.
- Next state is IDLE.

**Bus rules**
- OE must never be 0 while WE = 0, or while the block is driving `Data_CPU`. This avoids contention with Mem2IO, which drives `Data_CPU` when WE = 1 and OE = 0.

**Boundary conditions**
- `req` outside IDLE is ignored; no queueing.
- Input changes after acceptance have no effect on the access in progress.
- `be` = 00: the sequence still runs and `done` pulses. UB = LB = 1 throughout, and `rdata` is still captured.
- A write never modifies `rdata`.

**Reset** (asynchronous, at any point, including mid-access)
- State goes to IDLE.
- All active-low controls = 1; `Data_CPU` = Z.
- `A` = 0, `rdata` = 0, `busy` = 0, `done` = 0, counter = 0.

## Timing

- Accepting edge = edge 0 (IDLE with `req` = 1).
- SETUP = cycle 1; ACCESS = cycles 2 .. WAIT_STATES+1; RECOVER = cycle WAIT_STATES+2.
- `done` is high in cycle WAIT_STATES+2. For a read, `rdata` is valid from that cycle onward.
- Default `WAIT_STATES` = 2: `done` in cycle 4, and the minimum request spacing is 5 cycles (a mandatory IDLE cycle follows RECOVER).
- Throughput: one access per WAIT_STATES+3 cycles.
- All outputs except `Data_CPU` tri-state control are registered or decoded from state only.

## Structure

- Package `slc3_mem_pkg`:
  - `mem_state_t` enum (IDLE, SETUP, ACCESS, RECOVER).
  - `MEM_IDLE_CTRL` constant (all controls deasserted).
  - Shared default widths.
- No sub-module: the counter and FSM live inline in one module. The tri-state is a single continuous assign gated by the `drive_en` register.

## Test plan

1. Reset mid-ACCESS of a write, `WAIT_STATES` = 2 → same cycle: WE = 1, CE = 1, `Data_CPU` = Z, `busy` = 0. After release, a read of 0x00010 completes normally.
2. Read `addr` = 0x00123, `be` = 11, SRAM model returns 0xBEEF → OE = 0 and CE = 0 in cycles 1–3, WE = 1 throughout, `done` in cycle 4, `rdata` = 0xBEEF.
3. Write `addr` = 0x0FFFF, `wdata` = 0x1234 → WE = 0 only in cycles 2–3, OE = 1 throughout. `Data_CPU` = 0x1234 in cycles 1–4. Mem2IO hex outputs show 4, 3, 2, 1.
4. Upper-byte write (`be` = 10) → UB = 0, LB = 1 for cycles 1–4; `rdata` is unchanged from the previous read.
5. `req` held high continuously for `WAIT_STATES` = 1 and 15 → `done` spacing is 4 and 18 cycles. `req` pulses while `busy` are ignored.

Source files
------------

// File: rtl/slc3_mem_pkg.sv
// slc3_mem_pkg
// Shared types and constants for the SLC-3 SRAM access sequencer.
//   mem_state_t   : sequencer states (IDLE, SETUP, ACCESS, RECOVER)
//   mem_ctrl_t    : bundle of the active-low SRAM control strobes
//   MEM_IDLE_CTRL : all strobes deasserted (every bit high)
//   SLC3_ADDR_W / SLC3_DATA_W / SLC3_CNT_W : default widths
package slc3_mem_pkg;

   localparam int SLC3_ADDR_W = 20;
   localparam int SLC3_DATA_W = 16;
   localparam int SLC3_CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      ACCESS  = 2'd2,
      RECOVER = 2'd3
   } mem_state_t;

   typedef struct packed {
      logic ce;
      logic oe;
      logic we;
      logic ub;
      logic lb;
   } mem_ctrl_t;

   localparam mem_ctrl_t MEM_IDLE_CTRL = '{ce: 1'b1, oe: 1'b1, we: 1'b1, ub: 1'b1, lb: 1'b1};

endpackage

// File: rtl/slc3_mem_ctrl.sv
// slc3_mem_ctrl
// Turns a single-cycle CPU request into a timed SRAM access:
// IDLE -> SETUP (1) -> ACCESS (WAIT_STATES) -> RECOVER (1) -> IDLE.
// Ports:
//   Clk, Reset (async, active-high)
//   req, we_req, be[1:0], addr, wdata : request, sampled only in IDLE
//   busy   : high in SETUP/ACCESS/RECOVER
//   done   : high for the single RECOVER cycle
//   rdata  : last captured read data
//   A, CE, OE, WE, UB, LB : SRAM address and active-low strobes
//   Data_CPU : shared bus, driven by this block only for writes
module slc3_mem_ctrl
   import slc3_mem_pkg::*;
#(
   parameter int WAIT_STATES = 2,
   parameter int ADDR_W      = SLC3_ADDR_W,
   parameter int DATA_W      = SLC3_DATA_W
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              req,
   input  logic              we_req,
   input  logic [1:0]        be,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] A,
   output logic              CE,
   output logic              OE,
   output logic              WE,
   output logic              UB,
   output logic              LB,
   inout  wire  [DATA_W-1:0] Data_CPU
);

   // The counter is 4 bits wide, so only 1..15 wait states can be represented.
   generate
      if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait_states
         $error("slc3_mem_ctrl: WAIT_STATES must be in 1..15");
      end
   endgenerate

   localparam logic [SLC3_CNT_W-1:0] LAST_CNT = SLC3_CNT_W'(WAIT_STATES - 1);

   mem_state_t              state;
   mem_state_t              next_state;
   logic [SLC3_CNT_W-1:0]   cnt;
   logic                    we_lat;
   logic [1:0]              be_lat;
   logic [DATA_W-1:0]       wdata_lat;
   logic                    drive_en;
   mem_ctrl_t               ctrl;

   // State register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; req is only looked at in IDLE so busy-time requests drop.
   always_comb begin
      next_state = IDLE;
      case (state)
         IDLE: begin
            if (req) begin
               next_state = SETUP;
            end else begin
               next_state = IDLE;
            end
         end
         SETUP:  next_state = ACCESS;
         ACCESS: begin
            if (cnt == LAST_CNT) begin
               next_state = RECOVER;
            end else begin
               next_state = ACCESS;
            end
         end
         RECOVER: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Request latch, wait counter, read capture and bus-drive enable.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         A         <= '0;
         we_lat    <= 1'b0;
         be_lat    <= 2'b00;
         wdata_lat <= '0;
         cnt       <= '0;
         rdata     <= '0;
         drive_en  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  A         <= addr;
                  we_lat    <= we_req;
                  be_lat    <= be;
                  wdata_lat <= wdata;
                  drive_en  <= we_req;
               end
               cnt <= '0;
            end
            SETUP: cnt <= '0;
            ACCESS: begin
               if (cnt == LAST_CNT) begin
                  cnt <= '0;
                  // Sampled on the edge leaving the last ACCESS cycle, while OE is still low.
                  if (!we_lat) begin
                     rdata <= Data_CPU;
                  end
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            // Bus stays driven through RECOVER for data hold after WE rises.
            RECOVER: drive_en <= 1'b0;
            default: drive_en <= 1'b0;
         endcase
      end
   end

   // Strobe decode from state and latched request; OE stays high for writes
   // so it can never be low while WE is low or while we drive the bus.
   always_comb begin
      ctrl = MEM_IDLE_CTRL;
      busy = 1'b1;
      done = 1'b0;
      case (state)
         IDLE: begin
            ctrl = MEM_IDLE_CTRL;
            busy = 1'b0;
         end
         SETUP: begin
            ctrl.ce = 1'b0;
            ctrl.oe = we_lat;
            ctrl.we = 1'b1;
            ctrl.ub = ~be_lat[1];
            ctrl.lb = ~be_lat[0];
         end
         ACCESS: begin
            ctrl.ce = 1'b0;
            ctrl.oe = we_lat;
            ctrl.we = ~we_lat;
            ctrl.ub = ~be_lat[1];
            ctrl.lb = ~be_lat[0];
         end
         RECOVER: begin
            ctrl.ce = 1'b0;
            ctrl.oe = 1'b1;
            ctrl.we = 1'b1;
            ctrl.ub = ~be_lat[1];
            ctrl.lb = ~be_lat[0];
            done    = 1'b1;
         end
         default: begin
            ctrl = MEM_IDLE_CTRL;
            busy = 1'b0;
         end
      endcase
   end

   assign CE = ctrl.ce;
   assign OE = ctrl.oe;
   assign WE = ctrl.we;
   assign UB = ctrl.ub;
   assign LB = ctrl.lb;

   assign Data_CPU = drive_en ? wdata_lat : {DATA_W{1'bz}};

endmodule

// File: tb/tb_slc3_mem_ctrl.sv
// tb_slc3_mem_ctrl
// Directed bench for slc3_mem_ctrl: a WAIT_STATES=2 instance with a
// simple SRAM read model on the bus, plus WAIT_STATES=1 and 15 instances
// used for back-to-back request spacing.
module tb_slc3_mem_ctrl;

   localparam int AW = 20;
   localparam int DW = 16;

   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   logic          req, we_req, req_hold;
   logic [1:0]    be;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   wire           busy, done, CE, OE, WE, UB, LB;
   wire [DW-1:0]  rdata;
   wire [AW-1:0]  A;
   wire [DW-1:0]  Data_CPU;

   // SRAM read model plus a probe driver used to show the DUT is off the bus.
   logic [DW-1:0] sram_val, probe_val;
   logic          probe_en;
   wire           sram_en = (!CE && !OE && WE);
   assign Data_CPU = probe_en ? probe_val : (sram_en ? sram_val : 16'hzzzz);

   wire busy1, done1, ce1, oe1, we1, ub1, lb1;
   wire [DW-1:0] rdata1, data1;
   wire [AW-1:0] a1;
   wire busy15, done15, ce15, oe15, we15, ub15, lb15;
   wire [DW-1:0] rdata15, data15;
   wire [AW-1:0] a15;

   int checks = 0;
   int errors = 0;

   slc3_mem_ctrl #(.WAIT_STATES(2), .ADDR_W(AW), .DATA_W(DW)) dut (
      .Clk(Clk), .Reset(Reset), .req(req), .we_req(we_req), .be(be), .addr(addr),
      .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .A(A), .CE(CE),
      .OE(OE), .WE(WE), .UB(UB), .LB(LB), .Data_CPU(Data_CPU));

   slc3_mem_ctrl #(.WAIT_STATES(1), .ADDR_W(AW), .DATA_W(DW)) dut1 (
      .Clk(Clk), .Reset(Reset), .req(req_hold), .we_req(1'b0), .be(2'b11),
      .addr(20'h00001), .wdata(16'h0000), .busy(busy1), .done(done1), .rdata(rdata1),
      .A(a1), .CE(ce1), .OE(oe1), .WE(we1), .UB(ub1), .LB(lb1), .Data_CPU(data1));

   slc3_mem_ctrl #(.WAIT_STATES(15), .ADDR_W(AW), .DATA_W(DW)) dut15 (
      .Clk(Clk), .Reset(Reset), .req(req_hold), .we_req(1'b0), .be(2'b11),
      .addr(20'h00002), .wdata(16'h0000), .busy(busy15), .done(done15), .rdata(rdata15),
      .A(a15), .CE(ce15), .OE(oe15), .WE(we15), .UB(ub15), .LB(lb15), .Data_CPU(data15));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a request at the current negedge; after the accepting edge the
   // inputs are scrambled to show the access uses only latched values.
   task automatic start(input logic w, input logic [1:0] b, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
      req = 1'b1; we_req = w; be = b; addr = a; wdata = d;
      @(negedge Clk);
      req = 1'b0; we_req = ~w; be = ~b; addr = ~a; wdata = ~d;
   endtask

   initial begin
      int first1, gap1, first15, gap15;
      logic p1, p15;
      Reset = 1'b1; req = 1'b0; we_req = 1'b0; be = 2'b00; addr = '0; wdata = '0;
      sram_val = '0; probe_val = '0; probe_en = 1'b0; req_hold = 1'b0;
      repeat (2) @(negedge Clk);

      // Reset state
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ctrl", {CE, OE, WE, UB, LB}, 5'b11111);
      check("rst_A", A, 0);
      check("rst_rdata", rdata, 0);
      Reset = 1'b0;
      probe_en = 1'b1; probe_val = 16'hA5A5;
      #1 check("idle_bus_free", Data_CPU, 16'hA5A5);
      probe_en = 1'b0;

      // Read 0x00123, SRAM returns 0xBEEF
      @(negedge Clk);
      sram_val = 16'hBEEF;
      start(1'b0, 2'b11, 20'h00123, 16'h0000);
      check("rd_c1_A", A, 20'h00123);
      check("rd_c1_busy", busy, 1);
      check("rd_c1_done", done, 0);
      check("rd_c1_ctrl", {CE, OE, WE, UB, LB}, 5'b00100);
      @(negedge Clk);
      check("rd_c2_ctrl", {CE, OE, WE}, 3'b001);
      @(negedge Clk);
      check("rd_c3_ctrl", {CE, OE, WE}, 3'b001);
      req = 1'b1;  // ignored while busy
      @(negedge Clk);
      req = 1'b0;
      check("rd_c4_done", done, 1);
      check("rd_c4_ctrl", {CE, OE, WE}, 3'b011);
      check("rd_c4_rdata", rdata, 16'hBEEF);
      @(negedge Clk);
      check("rd_c5_busy", busy, 0);
      check("rd_c5_done", done, 0);
      check("rd_c5_ctrl", {CE, OE, WE}, 3'b111);
      @(negedge Clk);
      check("rd_ignored_req", busy, 0);

      // Write 0x1234 to 0x0FFFF
      start(1'b1, 2'b11, 20'h0FFFF, 16'h1234);
      for (int c = 1; c <= 4; c++) begin
         check("wr_data", Data_CPU, 16'h1234);
         check("wr_oe", OE, 1);
         check("wr_ce", CE, 0);
         check("wr_we", WE, (c == 2 || c == 3) ? 1'b0 : 1'b1);
         check("wr_done", done, (c == 4) ? 1'b1 : 1'b0);
         check("wr_A", A, 20'h0FFFF);
         @(negedge Clk);
      end
      check("wr_c5_busy", busy, 0);
      check("wr_rdata_kept", rdata, 16'hBEEF);

      // Upper-byte write
      start(1'b1, 2'b10, 20'h00200, 16'h5678);
      for (int c = 1; c <= 4; c++) begin
         check("ub_ublb", {UB, LB}, 2'b01);
         @(negedge Clk);
      end
      check("ub_rdata_kept", rdata, 16'hBEEF);
      check("ub_ublb_idle", {UB, LB}, 2'b11);

      // Read with no byte enables still runs and captures
      sram_val = 16'h0F0F;
      start(1'b0, 2'b00, 20'h00300, 16'h0000);
      for (int c = 1; c <= 4; c++) begin
         check("be0_ublb", {UB, LB}, 2'b11);
         check("be0_done", done, (c == 4) ? 1'b1 : 1'b0);
         if (c < 4) @(negedge Clk);
      end
      check("be0_rdata", rdata, 16'h0F0F);
      @(negedge Clk);

      // Reset in the middle of a write's ACCESS phase
      start(1'b1, 2'b11, 20'h00400, 16'hCAFE);
      @(negedge Clk);
      check("rstw_c2_we", WE, 0);
      check("rstw_c2_data", Data_CPU, 16'hCAFE);
      #2 Reset = 1'b1;
      #1;
      check("rstw_we", WE, 1);
      check("rstw_ce", CE, 1);
      check("rstw_busy", busy, 0);
      check("rstw_done", done, 0);
      check("rstw_A", A, 0);
      check("rstw_rdata", rdata, 0);
      probe_en = 1'b1; probe_val = 16'hA5A5;
      #1 check("rstw_bus_free", Data_CPU, 16'hA5A5);
      probe_en = 1'b0;
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      sram_val = 16'h7E57;
      start(1'b0, 2'b11, 20'h00010, 16'h0000);
      check("post_rst_A", A, 20'h00010);
      repeat (3) @(negedge Clk);
      check("post_rst_done", done, 1);
      check("post_rst_rdata", rdata, 16'h7E57);
      @(negedge Clk);

      // Continuous req on WAIT_STATES = 1 and 15 instances
      first1 = 0; gap1 = 0; first15 = 0; gap15 = 0;
      p1 = 1'b0; p15 = 1'b0;
      req_hold = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge Clk);
         if (done1 && !p1) begin
            if (first1 == 0) first1 = k;
            else if (gap1 == 0) gap1 = k - first1;
         end
         if (done15 && !p15) begin
            if (first15 == 0) first15 = k;
            else if (gap15 == 0) gap15 = k - first15;
         end
         p1 = done1;
         p15 = done15;
      end
      req_hold = 1'b0;
      check("ws1_first_done", first1, 3);
      check("ws1_spacing", gap1, 4);
      check("ws15_first_done", first15, 17);
      check("ws15_spacing", gap15, 18);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
